// File: rtl/key_input_filter.sv
// rtl/key_input_filter.sv - debounced keyboard move/jump filter with jump request handshake
module key_input_filter #(
  parameter logic [7:0] KEY_LEFT        = 8'h04,
  parameter logic [7:0] KEY_RIGHT       = 8'h07,
  parameter logic [7:0] KEY_JUMP        = 8'h2C,
  parameter int         DEBOUNCE_FRAMES = 2,
  parameter int         COOLDOWN_FRAMES = 8
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [1:0] move_dir,
  output logic       jump_req,
  input  logic       jump_ack,
  output logic [7:0] jump_count
);

  // Key slots inside the packed per-key vectors.
  localparam int K_LEFT  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_JUMP  = 2;
  localparam int NKEYS   = 3;

  localparam logic [4:0] DEB_LIMIT = 5'(DEBOUNCE_FRAMES);
  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_REL = 2'd2,
    ST_COOL     = 2'd3
  } jump_state_t;

  // A zero code means "no key", so a key parameterised to zero can never be pressed.
  function automatic logic key_match(input logic [7:0] code,
                                     input logic [7:0] k0,
                                     input logic [7:0] k1);
    return (code != 8'h00) && ((k0 == code) || (k1 == code));
  endfunction

  logic                   fsync_meta;
  logic                   fsync;
  logic                   fsync_prev;
  logic                   frame_tick;
  logic [NKEYS-1:0]       raw;
  logic [NKEYS-1:0]       db;
  logic [NKEYS-1:0]       db_next;
  logic [NKEYS-1:0][3:0]  stab;
  logic [NKEYS-1:0][3:0]  stab_next;
  logic                   jump_rise;
  jump_state_t            state;
  logic [7:0]             cool_cnt;

  // Two-flop synchronizer plus edge history; all flops reset high so the
  // first tick after reset needs a real low-then-high on frame_clk.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      fsync_meta <= 1'b1;
      fsync      <= 1'b1;
      fsync_prev <= 1'b1;
    end else begin
      fsync_meta <= frame_clk;
      fsync      <= fsync_meta;
      fsync_prev <= fsync;
    end
  end

  assign frame_tick = fsync & ~fsync_prev;

  assign raw[K_LEFT]  = key_match(KEY_LEFT,  keycode0, keycode1);
  assign raw[K_RIGHT] = key_match(KEY_RIGHT, keycode0, keycode1);
  assign raw[K_JUMP]  = key_match(KEY_JUMP,  keycode0, keycode1);

  // Per-key stability counting: only frame ticks sample the raw keys, a run of
  // DEBOUNCE_FRAMES differing samples flips the debounced state.
  always_comb begin
    db_next   = db;
    stab_next = stab;
    if (frame_tick) begin
      for (int i = 0; i < NKEYS; i++) begin
        if (raw[i] != db[i]) begin
          if (({1'b0, stab[i]} + 5'd1) >= DEB_LIMIT) begin
            db_next[i]   = ~db[i];
            stab_next[i] = 4'd0;
          end else begin
            stab_next[i] = stab[i] + 4'd1;
          end
        end else begin
          stab_next[i] = 4'd0;
        end
      end
    end
  end

  // Debounced key state and stability counters.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      db   <= '0;
      stab <= '0;
    end else begin
      db   <= db_next;
      stab <= stab_next;
    end
  end

  // Direction output follows the registered debounced keys one cycle later;
  // opposing keys cancel.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      move_dir <= 2'b00;
    end else begin
      case ({db[K_LEFT], db[K_RIGHT]})
        2'b01:   move_dir <= 2'b01;
        2'b10:   move_dir <= 2'b10;
        default: move_dir <= 2'b00;
      endcase
    end
  end

  // A new press is the edge on which the debounced jump key becomes set.
  assign jump_rise = db_next[K_JUMP] & ~db[K_JUMP];

  // Jump handshake: request until acknowledged, then wait for release and
  // sit out the cooldown so a held or quickly repeated key cannot re-fire.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      jump_req   <= 1'b0;
      jump_count <= 8'h00;
      cool_cnt   <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (jump_rise) begin
            state    <= ST_REQ;
            jump_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (jump_ack) begin
            state      <= ST_WAIT_REL;
            jump_req   <= 1'b0;
            jump_count <= jump_count + 8'd1;
          end
        end
        ST_WAIT_REL: begin
          if (!db[K_JUMP]) begin
            if (COOL_LOAD == 8'd0) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_COOL;
              cool_cnt <= COOL_LOAD;
            end
          end
        end
        ST_COOL: begin
          if (frame_tick) begin
            cool_cnt <= cool_cnt - 8'd1;
            if (cool_cnt == 8'd1) begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          jump_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
